// File: rtl/elevator_dispatcher_pkg.sv
// Shared types and helpers for the elevator dispatcher: floor index sizing,
// unsigned distance, and the direction encoding reserved for the next revision.
package elev_pkg;

    localparam int MAX_FLOOR_W = 16;

    typedef logic [MAX_FLOOR_W-1:0] floor_idx_t;
    typedef logic [MAX_FLOOR_W:0]   floor_dist_t;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

    function automatic int floor_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic floor_dist_t abs_diff(input floor_idx_t a, input floor_idx_t b);
        return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction

endpackage

// File: rtl/elevator_dispatcher_claim.sv
// Per-car claim tracker: holds a car as claimed from dispatch until it reports
// busy, or drops the claim with a one-cycle pulse after CLAIM_TIMEOUT cycles.
module car_claim_tracker #(
    parameter int CLAIM_TIMEOUT = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_grant,
    input  logic i_car_busy,
    output logic o_claimed,
    output logic o_timeout_pulse
);

    localparam int CNT_W = $clog2(CLAIM_TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_claimed;
    logic             r_timeout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_claimed <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (i_grant) begin
                r_claimed <= 1'b1;
                r_cnt     <= '0;
            end else if (r_claimed && i_car_busy) begin
                r_claimed <= 1'b0;
                r_cnt     <= '0;
            end else if (r_claimed) begin
                // Counter value k is visible k cycles after the grant edge.
                if (r_cnt == CNT_W'(CLAIM_TIMEOUT - 1)) begin
                    r_claimed <= 1'b0;
                    r_cnt     <= '0;
                    r_timeout <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_claimed       = r_claimed;
    assign o_timeout_pulse = r_timeout;

endmodule

// File: rtl/elevator_dispatcher.sv
// Hall-request dispatcher: latches floor requests, absorbs those already served
// by an engaged car, and dispatches one floor per cycle to the nearest idle car.
module elevator_dispatcher
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS    = 4,
    parameter int NUM_CARS      = 2,
    parameter int FLOOR_W       = floor_w(NUM_FLOORS),
    parameter int CLAIM_TIMEOUT = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_FLOORS-1:0]         i_floor_req,
    input  logic [NUM_CARS*FLOOR_W-1:0]   i_car_floor,
    input  logic [NUM_CARS-1:0]           i_car_busy,
    output logic [NUM_CARS*FLOOR_W-1:0]   o_car_target,
    output logic [NUM_CARS-1:0]           o_car_move_en,
    output logic [NUM_FLOORS-1:0]         o_req_ack,
    output logic [NUM_FLOORS-1:0]         o_pending,
    output logic [NUM_CARS-1:0]           o_claim_timeout
);

    localparam int DIST_W = FLOOR_W + 1;

    logic [NUM_FLOORS-1:0]              r_pending;
    logic [NUM_FLOORS-1:0]              r_req_ack;
    logic [NUM_CARS-1:0]                r_move_en;
    logic [NUM_CARS-1:0][FLOOR_W-1:0]   r_target;
    logic [FLOOR_W-1:0]                 r_rr_ptr;

    logic [NUM_FLOORS-1:0]              w_engaged;
    logic [NUM_FLOORS-1:0]              w_absorb;
    logic [NUM_FLOORS-1:0]              w_cand;
    logic [NUM_FLOORS-1:0]              w_disp_oh;
    logic [NUM_FLOORS-1:0]              w_pending_nxt;
    logic [NUM_CARS-1:0]                w_claimed;
    logic [NUM_CARS-1:0]                w_avail;
    logic [NUM_CARS-1:0]                w_grant;
    logic [NUM_CARS-1:0]                w_timeout;
    logic [FLOOR_W-1:0]                 w_sel_floor;
    logic                               w_sel_found;
    logic                               w_car_found;
    logic [DIST_W-1:0]                  w_best_dist;
    logic [DIST_W-1:0]                  w_dist;
    int                                 w_f;

    // A car counts as engaged on its target while claimed or busy.
    always_comb begin
        w_engaged = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            for (int i = 0; i < NUM_CARS; i++) begin
                if ((i_car_busy[i] || w_claimed[i]) && (r_target[i] == FLOOR_W'(f)))
                    w_engaged[f] = 1'b1;
            end
        end
    end

    assign w_absorb = r_pending & w_engaged;
    assign w_cand   = r_pending & ~w_engaged;
    assign w_avail  = ~(i_car_busy | w_claimed);

    // Round-robin floor pick starting at r_rr_ptr.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_floor = '0;
        w_f         = 0;
        for (int k = 0; k < NUM_FLOORS; k++) begin
            w_f = (int'(r_rr_ptr) + k) % NUM_FLOORS;
            if (!w_sel_found && w_cand[w_f]) begin
                w_sel_found = 1'b1;
                w_sel_floor = FLOOR_W'(w_f);
            end
        end
    end

    // Nearest available car; strict compare keeps ties on the lowest index.
    always_comb begin
        w_grant     = '0;
        w_car_found = 1'b0;
        w_best_dist = '1;
        w_dist      = '0;
        for (int i = 0; i < NUM_CARS; i++) begin
            w_dist = DIST_W'(abs_diff(floor_idx_t'(i_car_floor[i*FLOOR_W +: FLOOR_W]),
                                      floor_idx_t'(w_sel_floor)));
            if (w_sel_found && w_avail[i] && (!w_car_found || (w_dist < w_best_dist))) begin
                w_car_found = 1'b1;
                w_best_dist = w_dist;
                w_grant     = '0;
                w_grant[i]  = 1'b1;
            end
        end
    end

    assign w_disp_oh     = w_car_found ? (NUM_FLOORS'(1) << w_sel_floor) : '0;
    assign w_pending_nxt = (r_pending | i_floor_req) & ~(w_disp_oh | w_absorb);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= '0;
            r_req_ack <= '0;
            r_move_en <= '0;
            r_target  <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_req_ack <= w_disp_oh | w_absorb;
            r_move_en <= w_grant;
            for (int i = 0; i < NUM_CARS; i++) begin
                if (w_grant[i])
                    r_target[i] <= w_sel_floor;
            end
            if (w_car_found)
                r_rr_ptr <= (w_sel_floor == FLOOR_W'(NUM_FLOORS - 1)) ? '0 : w_sel_floor + 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_CARS; gi++) begin : g_car
        car_claim_tracker #(
            .CLAIM_TIMEOUT (CLAIM_TIMEOUT)
        ) u_trk (
            .i_clk           (i_clk),
            .i_rst           (i_rst),
            .i_grant         (w_grant[gi]),
            .i_car_busy      (i_car_busy[gi]),
            .o_claimed       (w_claimed[gi]),
            .o_timeout_pulse (w_timeout[gi])
        );
    end

    assign o_car_target    = r_target;
    assign o_car_move_en   = r_move_en;
    assign o_req_ack       = r_req_ack;
    assign o_pending       = r_pending;
    assign o_claim_timeout = w_timeout;

endmodule

// File: doc/elevator_dispatcher.md
Name: elevator_dispatcher

Overview:
Parametrised successor to the two-car scheduler. It latches hall requests for NUM_FLOORS floors and dispatches them to NUM_CARS cars by nearest-idle-car selection, with round-robin fairness across floors. Each dispatched car is held as "claimed" until the car reports busy, or until a timeout expires. Requests for a floor that a car is already heading to are absorbed instead of dispatched twice. It sits between the hall-button front end and the per-car motion controllers.

Parameters:
NUM_FLOORS, 4, number of floors; must be 2 or more.
NUM_CARS, 2, number of cars; must be 1 or more.
FLOOR_W, $clog2(NUM_FLOORS), width of a floor index (derived; do not override).
CLAIM_TIMEOUT, 8, cycles a claim may wait for car_busy before it is dropped; must be 1 or more.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
floor_req  in  NUM_FLOORS  hall request bitmask; bit f = floor f; level or pulse
car_floor  in  NUM_CARS*FLOOR_W  packed current floor per car; car i occupies bits [i*FLOOR_W +: FLOOR_W]
car_busy  in  NUM_CARS  car i is executing a move or door cycle
car_target  out  NUM_CARS*FLOOR_W  packed last-assigned target per car
car_move_en  out  NUM_CARS  one-cycle dispatch strobe per car
req_ack  out  NUM_FLOORS  one-cycle pulse when floor f is dispatched or absorbed
pending  out  NUM_FLOORS  registered pending-request mask
claim_timeout  out  NUM_CARS  one-cycle pulse when car i's claim expires without car_busy

Behaviour:
- Reset (rst high at a clk edge): pending=0, car_target=0, car_move_en=0, req_ack=0, claim_timeout=0, rr_ptr=0, all claims cleared, all counters cleared. Reset mid-operation discards every pending request and claim.
- A car is available when car_busy[i]=0 and claimed[i]=0.
- A car is engaged on floor f when (car_busy[i]=1 or claimed[i]=1) and car_target[i]=f.
- Absorb: if pending[f]=1 and some car is engaged on f, then req_ack[f] pulses and pending[f] clears. No dispatch occurs. All such floors are absorbed in the same cycle.
- Dispatch (at most one per cycle):
  - Floor selection: take the first floor f, in cyclic order starting at rr_ptr, with pending[f]=1 and not absorbed this cycle.
  - Car selection: take the available car minimising |car_floor[i]-f|, computed unsigned in FLOOR_W+1 bits. Ties go to the lowest index.
  - If no car is available, nothing is dispatched and pending is retained.
- On dispatch, registered at the next edge: car_target[i]<=f, car_move_en[i]<=1 for exactly one cycle, req_ack[f]<=1, pending[f] cleared, claimed[i] set, counter[i]<=0, rr_ptr<=(f+1) mod NUM_FLOORS.
- Pending update: pending <= (pending | floor_req) & ~(dispatched | absorbed). A floor_req bit arriving in the same cycle that floor is dispatched or absorbed is treated as served and is not re-latched.
- Latency: floor_req sampled high at edge N gives pending at edge N. With a car available, car_move_en and req_ack are high after edge N+1, i.e. 2 edges from request to strobe.
- Claim: cleared at the first edge where car_busy[i]=1. Otherwise the counter increments each cycle. When the counter reaches CLAIM_TIMEOUT, the claim clears and claim_timeout[i] pulses for one cycle; the car becomes available again on the following cycle. car_target[i] holds its value.
- A dispatch to a car whose car_floor already equals f is legal (distance 0). That car is expected to open its doors and raise car_busy.
- car_target is stable between dispatches. Outputs are never X after reset.

Decomposition:
- Package elev_pkg holds:
  - floor_idx_t sizing helper and an abs_diff function;
  - the DIR_IDLE/DIR_UP/DIR_DOWN encoding, reserved for the direction-aware next revision.
- Sub-module car_claim_tracker, one instance per car:
  - inputs: clk, rst, grant, car_busy;
  - outputs: claimed, timeout_pulse;
  - owns the CLAIM_TIMEOUT counter.
- Floor/car selection stays combinational in the top module.

Test Plan:
- Reset, then floor_req=4'b1000 pulse, cars at floors 0 and 2, both idle -> 2 edges later car_move_en=2'b10, car1 target=3, req_ack=4'b1000, pending=0.
- floor_req=4'b0101 in one cycle, both cars idle at floor 0 -> cycle A: car0 to floor 0 and ack[0]. Cycle B: car1 to floor 2 and ack[2]. rr_ptr ends at 3.
- Car0 claimed with target 2 and car_busy low for 8 cycles -> claim_timeout[0] pulses on the 8th cycle after grant. Pending floor 1 is then dispatched to car0 the following cycle.
- Car1 busy with target 3 when floor_req[3] pulses -> req_ack[3] pulses, car_move_en stays 0, pending[3]=0.
- Both cars busy, floor_req=4'b0010 held -> pending[1] stays 1 with no ack. car_busy[0] falls -> dispatch to car0 on the next edge.
- rst asserted while pending=4'b1111 and claims are active -> the next edge clears all outputs. No strobe occurs until new requests arrive.
